// File: rtl/button_input_debouncer.sv
// Conditions asynchronous board inputs into clean, clock-synchronous levels.
// Each channel has a synchronizer, a stability counter, a debounced level and press/release pulses.
module button_input_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_event
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [CNT_W-1:0] cnt_r [WIDTH];
  state_t           state_s [WIDTH];

  // Two-flop synchronizer, no logic between the stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= raw_in;
      sync2_r <= sync1_r;
    end
  end

  // Channel is pending whenever the synchronized input disagrees with the accepted level
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_s[i] = ST_STABLE;
      if (sync2_r[i] != level_out[i]) begin
        state_s[i] = ST_PENDING;
      end else begin
        state_s[i] = ST_STABLE;
      end
    end
  end

  // Per-channel stability counter, level acceptance and one-cycle pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_out     <= {WIDTH{1'b0}};
      press_pulse   <= {WIDTH{1'b0}};
      release_pulse <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        press_pulse[i]   <= 1'b0;
        release_pulse[i] <= 1'b0;
        case (state_s[i])
          ST_STABLE: begin
            cnt_r[i] <= {CNT_W{1'b0}};
          end
          ST_PENDING: begin
            // A bounce back before acceptance lands in ST_STABLE, so partial counts never survive
            if (cnt_r[i] == CNT_MAX) begin
              level_out[i]     <= sync2_r[i];
              press_pulse[i]   <= sync2_r[i];
              release_pulse[i] <= ~sync2_r[i];
              cnt_r[i]         <= {CNT_W{1'b0}};
            end else begin
              cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
          end
          default: begin
            cnt_r[i] <= {CNT_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign any_event = (|press_pulse) | (|release_pulse);

endmodule
